// File: rtl/time_set_ctrl_if.sv
// Button/tick inputs, live time inputs and edit/load outputs of the time-set controller.
interface time_set_ctrl_if;
   logic       sec_tick;
   logic       mode_pulse;
   logic       inc_pulse;
   logic [3:0] cur_hour_tens;
   logic [3:0] cur_hour_units;
   logic [3:0] cur_min_tens;
   logic [3:0] cur_min_units;
   logic       cur_am;
   logic       run_en;
   logic       load;
   logic [3:0] ld_hour_tens;
   logic [3:0] ld_hour_units;
   logic [3:0] ld_min_tens;
   logic [3:0] ld_min_units;
   logic       ld_am;
   logic       blink_hour;
   logic       blink_min;
   logic [1:0] state;

   // Side that feeds strobes and live time in (debouncers/counters/bench).
   modport master (
      output sec_tick, mode_pulse, inc_pulse,
      output cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units, cur_am,
      input  run_en, load, ld_hour_tens, ld_hour_units, ld_min_tens, ld_min_units,
      input  ld_am, blink_hour, blink_min, state
   );

   // The controller itself.
   modport slave (
      input  sec_tick, mode_pulse, inc_pulse,
      input  cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units, cur_am,
      output run_en, load, ld_hour_tens, ld_hour_units, ld_min_tens, ld_min_units,
      output ld_am, blink_hour, blink_min, state
   );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-set controller: RUN -> SET_HOUR -> SET_MIN -> COMMIT, with edit registers,
// inactivity timeout and display blink phase. All outputs are registered.
module time_set_ctrl #(
   parameter int unsigned TIMEOUT_S = 10,
   parameter int unsigned TO_W      = 4
) (
   input  logic           clk,
   input  logic           rst,
   time_set_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10,
      COMMIT   = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic              run_en_q, run_en_d;
   logic              load_q, load_d;
   logic [3:0]        ht_q, ht_d, hu_q, hu_d, mt_q, mt_d, mu_q, mu_d;
   logic              am_q, am_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              phase_q, phase_d;
   logic              blink_hour_q, blink_hour_d;
   logic              blink_min_q, blink_min_d;
   logic              timeout_hit;
   logic              in_set_q;

   // Hour step 12->01..11->12 in BCD; 11->12 flips AM/PM; invalid hour restarts at 01.
   function automatic logic [8:0] hour_inc(input logic [3:0] t, input logic [3:0] u,
                                           input logic am);
      logic valid;
      valid = ((t == 4'd0) && (u >= 4'd1) && (u <= 4'd9)) ||
              ((t == 4'd1) && (u <= 4'd2));
      if (!valid)
         hour_inc = {am, 4'd0, 4'd1};
      else if ((t == 4'd1) && (u == 4'd2))
         hour_inc = {am, 4'd0, 4'd1};
      else if ((t == 4'd1) && (u == 4'd1))
         hour_inc = {~am, 4'd1, 4'd2};
      else if (u == 4'd9)
         hour_inc = {am, 4'd1, 4'd0};
      else
         hour_inc = {am, t, u + 4'd1};
   endfunction

   // Minute step 00..59 wrapping to 00 without hour carry; invalid minute restarts at 00.
   function automatic logic [7:0] min_inc(input logic [3:0] t, input logic [3:0] u);
      if ((t > 4'd5) || (u > 4'd9))
         min_inc = 8'h00;
      else if (u == 4'd9)
         min_inc = (t == 4'd5) ? 8'h00 : {t + 4'd1, 4'd0};
      else
         min_inc = {t, u + 4'd1};
   endfunction

   // Next-state, edit register, timeout and blink logic.
   always_comb begin
      state_d   = state_q;
      ht_d      = ht_q;
      hu_d      = hu_q;
      mt_d      = mt_q;
      mu_d      = mu_q;
      am_d      = am_q;
      to_cnt_d  = to_cnt_q;
      phase_d   = bus.sec_tick ? ~phase_q : phase_q;
      in_set_q  = (state_q == SET_HOUR) || (state_q == SET_MIN);
      timeout_hit = bus.sec_tick && (to_cnt_q == TO_W'(TIMEOUT_S - 1));

      // Pulses take priority over a coincident timeout tick; mode beats inc.
      case (state_q)
         RUN: begin
            if (bus.mode_pulse) begin
               ht_d    = bus.cur_hour_tens;
               hu_d    = bus.cur_hour_units;
               mt_d    = bus.cur_min_tens;
               mu_d    = bus.cur_min_units;
               am_d    = bus.cur_am;
               state_d = SET_HOUR;
            end
         end
         SET_HOUR: begin
            if (bus.mode_pulse)
               state_d = SET_MIN;
            else if (bus.inc_pulse)
               {am_d, ht_d, hu_d} = hour_inc(ht_q, hu_q, am_q);
            else if (timeout_hit)
               state_d = RUN;
         end
         SET_MIN: begin
            if (bus.mode_pulse)
               state_d = COMMIT;
            else if (bus.inc_pulse)
               {mt_d, mu_d} = min_inc(mt_q, mu_q);
            else if (timeout_hit)
               state_d = RUN;
         end
         default: state_d = RUN;
      endcase

      if ((state_d != state_q) || bus.mode_pulse || bus.inc_pulse)
         to_cnt_d = '0;
      else if (in_set_q && bus.sec_tick)
         to_cnt_d = to_cnt_q + TO_W'(1);

      if ((state_d != state_q) && ((state_d == SET_HOUR) || (state_d == SET_MIN)))
         phase_d = 1'b1;

      run_en_d     = (state_d == RUN);
      load_d       = (state_d == COMMIT);
      blink_hour_d = (state_d == SET_HOUR) && phase_d;
      blink_min_d  = (state_d == SET_MIN) && phase_d;
   end

   // State and output registers; reset loads 12:00 AM into the edit registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         run_en_q     <= 1'b1;
         load_q       <= 1'b0;
         ht_q         <= 4'd1;
         hu_q         <= 4'd2;
         mt_q         <= 4'd0;
         mu_q         <= 4'd0;
         am_q         <= 1'b1;
         to_cnt_q     <= '0;
         phase_q      <= 1'b1;
         blink_hour_q <= 1'b0;
         blink_min_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_en_q     <= run_en_d;
         load_q       <= load_d;
         ht_q         <= ht_d;
         hu_q         <= hu_d;
         mt_q         <= mt_d;
         mu_q         <= mu_d;
         am_q         <= am_d;
         to_cnt_q     <= to_cnt_d;
         phase_q      <= phase_d;
         blink_hour_q <= blink_hour_d;
         blink_min_q  <= blink_min_d;
      end
   end

   assign bus.state         = state_q;
   assign bus.run_en        = run_en_q;
   assign bus.load          = load_q;
   assign bus.ld_hour_tens  = ht_q;
   assign bus.ld_hour_units = hu_q;
   assign bus.ld_min_tens   = mt_q;
   assign bus.ld_min_units  = mu_q;
   assign bus.ld_am         = am_q;
   assign bus.blink_hour    = blink_hour_q;
   assign bus.blink_min     = blink_min_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: expectations queued with each stimulus step,
// popped and compared after the clock edge.
module tb_time_set_ctrl;

   typedef struct {
      string      tag;
      logic [1:0] st;
      logic       run_en;
      logic       load;
      logic [15:0] ld;
      logic       am;
      logic       bh;
      logic       bm;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   exp_t sb[$];

   time_set_ctrl_if bus();

   time_set_ctrl #(.TIMEOUT_S(10), .TO_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic expect_out(input string tag, input logic [1:0] st, input logic run_en,
                             input logic load, input logic [15:0] ld, input logic am,
                             input logic bh, input logic bm);
      exp_t e;
      e.tag = tag; e.st = st; e.run_en = run_en; e.load = load;
      e.ld = ld; e.am = am; e.bh = bh; e.bm = bm;
      sb.push_back(e);
   endtask

   task automatic cmp(input string tag, input string fld, input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
   endtask

   task automatic check_now();
      exp_t e;
      logic [15:0] ld_obs;
      if (sb.size() == 0) begin
         total++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      ld_obs = {bus.ld_hour_tens, bus.ld_hour_units, bus.ld_min_tens, bus.ld_min_units};
      cmp(e.tag, "state",  16'(bus.state),      16'(e.st));
      cmp(e.tag, "run_en", 16'(bus.run_en),     16'(e.run_en));
      cmp(e.tag, "load",   16'(bus.load),       16'(e.load));
      cmp(e.tag, "ld",     ld_obs,              e.ld);
      cmp(e.tag, "ld_am",  16'(bus.ld_am),      16'(e.am));
      cmp(e.tag, "blink_h",16'(bus.blink_hour), 16'(e.bh));
      cmp(e.tag, "blink_m",16'(bus.blink_min),  16'(e.bm));
   endtask

   // Drive one cycle of strobes, let the edge happen, compare against the queued result.
   task automatic cyc(input logic mode, input logic inc, input logic tick);
      bus.mode_pulse = mode;
      bus.inc_pulse  = inc;
      bus.sec_tick   = tick;
      @(posedge clk);
      #1;
      bus.mode_pulse = 1'b0;
      bus.inc_pulse  = 1'b0;
      bus.sec_tick   = 1'b0;
      check_now();
   endtask

   task automatic set_cur(input logic [15:0] t, input logic am);
      {bus.cur_hour_tens, bus.cur_hour_units, bus.cur_min_tens, bus.cur_min_units} = t;
      bus.cur_am = am;
   endtask

   initial begin
      bus.mode_pulse = 1'b0;
      bus.inc_pulse  = 1'b0;
      bus.sec_tick   = 1'b0;
      set_cur(16'h1158, 1'b1);
      #12;
      expect_out("reset", 2'b00, 1, 0, 16'h1200, 1, 0, 0);
      check_now();
      rst = 1'b0;

      // Live 11:58 AM -> edit to 12:01 PM and commit.
      expect_out("t2_mode",  2'b01, 0, 0, 16'h1158, 1, 1, 0); cyc(1, 0, 0);
      expect_out("t2_inc_h", 2'b01, 0, 0, 16'h1258, 0, 1, 0); cyc(0, 1, 0);
      expect_out("t2_to_min",2'b10, 0, 0, 16'h1258, 0, 0, 1); cyc(1, 0, 0);
      expect_out("t2_m59",   2'b10, 0, 0, 16'h1259, 0, 0, 1); cyc(0, 1, 0);
      expect_out("t2_m00",   2'b10, 0, 0, 16'h1200, 0, 0, 1); cyc(0, 1, 0);
      expect_out("t2_m01",   2'b10, 0, 0, 16'h1201, 0, 0, 1); cyc(0, 1, 0);
      expect_out("t2_commit",2'b11, 0, 1, 16'h1201, 0, 0, 0); cyc(1, 0, 0);
      expect_out("t2_run",   2'b00, 1, 0, 16'h1201, 0, 0, 0); cyc(0, 0, 0);
      expect_out("t2_inc_run",2'b00,1, 0, 16'h1201, 0, 0, 0); cyc(0, 1, 0);

      // 12 -> 01 keeps AM; 59 -> 00 leaves hour alone; then async reset mid-SET_MIN.
      set_cur(16'h1259, 1'b1);
      expect_out("t3_mode",  2'b01, 0, 0, 16'h1259, 1, 1, 0); cyc(1, 0, 0);
      expect_out("t3_h01",   2'b01, 0, 0, 16'h0159, 1, 1, 0); cyc(0, 1, 0);
      expect_out("t3_to_min",2'b10, 0, 0, 16'h0159, 1, 0, 1); cyc(1, 0, 0);
      expect_out("t3_m00",   2'b10, 0, 0, 16'h0100, 1, 0, 1); cyc(0, 1, 0);
      expect_out("t3_tick",  2'b10, 0, 0, 16'h0100, 1, 0, 0); cyc(0, 0, 1);
      rst = 1'b1;
      #1;
      expect_out("t1_rst_mid", 2'b00, 1, 0, 16'h1200, 1, 0, 0);
      check_now();
      #2;
      rst = 1'b0;

      // Timeout with no buttons; blink_hour follows the second phase.
      set_cur(16'h1030, 1'b0);
      expect_out("t4_mode", 2'b01, 0, 0, 16'h1030, 0, 1, 0); cyc(1, 0, 0);
      for (int k = 1; k <= 9; k++) begin
         expect_out($sformatf("t4_tick%0d", k), 2'b01, 0, 0, 16'h1030, 0,
                    (k % 2 == 0) ? 1'b1 : 1'b0, 0);
         cyc(0, 0, 1);
      end
      expect_out("t4_timeout", 2'b00, 1, 0, 16'h1030, 0, 0, 0); cyc(0, 0, 1);
      expect_out("t4_idle",    2'b00, 1, 0, 16'h1030, 0, 0, 0); cyc(0, 0, 0);

      // mode+inc together: mode wins; inc on the 10th tick keeps the edit alive.
      expect_out("t5_mode",     2'b01, 0, 0, 16'h1030, 0, 1, 0); cyc(1, 0, 0);
      expect_out("t5_mode_inc", 2'b10, 0, 0, 16'h1030, 0, 0, 1); cyc(1, 1, 0);
      for (int k = 1; k <= 9; k++) begin
         expect_out($sformatf("t5_tick%0d", k), 2'b10, 0, 0, 16'h1030, 0, 0,
                    (k % 2 == 0) ? 1'b1 : 1'b0);
         cyc(0, 0, 1);
      end
      expect_out("t5_inc_at10", 2'b10, 0, 0, 16'h1031, 0, 0, 1); cyc(0, 1, 1);
      for (int k = 1; k <= 9; k++) begin
         expect_out($sformatf("t5_re%0d", k), 2'b10, 0, 0, 16'h1031, 0, 0,
                    (k % 2 == 0) ? 1'b1 : 1'b0);
         cyc(0, 0, 1);
      end
      expect_out("t5_timeout", 2'b00, 1, 0, 16'h1031, 0, 0, 0); cyc(0, 0, 1);

      // Invalid live values and the 09 -> 10 hour step.
      set_cur(16'h0075, 1'b1);
      expect_out("t7_mode",  2'b01, 0, 0, 16'h0075, 1, 1, 0); cyc(1, 0, 0);
      expect_out("t7_h_inv", 2'b01, 0, 0, 16'h0175, 1, 1, 0); cyc(0, 1, 0);
      expect_out("t7_to_min",2'b10, 0, 0, 16'h0175, 1, 0, 1); cyc(1, 0, 0);
      expect_out("t7_m_inv", 2'b10, 0, 0, 16'h0100, 1, 0, 1); cyc(0, 1, 0);
      expect_out("t7_commit",2'b11, 0, 1, 16'h0100, 1, 0, 0); cyc(1, 0, 0);
      expect_out("t7_run",   2'b00, 1, 0, 16'h0100, 1, 0, 0); cyc(0, 0, 0);
      set_cur(16'h0909, 1'b0);
      expect_out("t8_mode",  2'b01, 0, 0, 16'h0909, 0, 1, 0); cyc(1, 0, 0);
      expect_out("t8_h10",   2'b01, 0, 0, 16'h1009, 0, 1, 0); cyc(0, 1, 0);
      expect_out("t8_to_min",2'b10, 0, 0, 16'h1009, 0, 0, 1); cyc(1, 0, 0);
      expect_out("t8_m10",   2'b10, 0, 0, 16'h1010, 0, 0, 1); cyc(0, 1, 0);
      expect_out("t8_commit",2'b11, 0, 1, 16'h1010, 0, 0, 0); cyc(1, 0, 0);
      expect_out("t8_run",   2'b00, 1, 0, 16'h1010, 0, 0, 0); cyc(0, 0, 0);

      if (sb.size() != 0) begin
         total++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
